game_ctrl: RTL and testbench

Match sequencer sitting between the VGA timing generator and `ball`. It issues `move` strobes and `ball_reset` serves to `ball`, and consumes its `broken0`/`broken1` pulses and `xloc` to keep per-player scores. It also detects out-of-bounds, ramps ball speed and declares the winner.

---
 rtl/game_ctrl_if.sv | 29 ++
 rtl/game_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_game_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Signal bundle between game_ctrl and its neighbours (raster timing, ball, buttons, score display).
// The controller takes the slave modport; whoever drives the raster and ball side takes master.
interface game_ctrl_if;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] xloc;
  logic       broken0;
  logic       broken1;
  logic       start;
  logic       move;
  logic       ball_reset;
  logic [7:0] score0;
  logic [7:0] score1;
  logic [2:0] speed;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  modport slave (
    input  pixpulse, hcount, vcount, xloc, broken0, broken1, start,
    output move, ball_reset, score0, score1, speed, game_over, winner, state
  );

  modport master (
    output pixpulse, hcount, vcount, xloc, broken0, broken1, start,
    input  move, ball_reset, score0, score1, speed, game_over, winner, state
  );
endinterface

// File: rtl/game_ctrl.sv
// Match sequencer: serves the ball, issues move strobes, keeps scores and declares the winner.
// Define GAME_CTRL_SPEEDUP_EN to compile in the hit-counter speed ramp (speed fixed at 1 otherwise).
module game_ctrl #(
  parameter logic [9:0] XMIN           = 10'd4,
  parameter logic [9:0] XMAX           = 10'd636,
  parameter logic [7:0] POINT_PTS      = 8'd5,
  parameter logic [7:0] BLOCK_PTS      = 8'd1,
  parameter logic [7:0] WIN_SCORE      = 8'd50,
  parameter logic [7:0] SERVE_FRAMES   = 8'd60,
  parameter logic [3:0] HITS_PER_SPEED = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

  state_e     state_q, state_d;
  logic       move_q, move_d;
  logic       ball_reset_q, ball_reset_d;
  logic [7:0] score0_q, score0_d;
  logic [7:0] score1_q, score1_d;
  logic [2:0] speed_q, speed_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       armed_q, armed_d;
  logic       start_q, start_d;
`ifdef GAME_CTRL_SPEEDUP_EN
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] hit_sum_s;
`endif

  logic       frame_tick_s;
  logic [9:0] line_ofs_s;
  logic       move_slot_s;
  logic       oob_left_s;
  logic       oob_right_s;
  logic [7:0] sum0_s;
  logic [7:0] sum1_s;
  logic       enter_serve_s;

  // Next-state, scoring, serve countdown and speed ramp for every register
  always_comb begin
    state_d       = state_q;
    move_d        = move_q;
    score0_d      = score0_q;
    score1_d      = score1_q;
    winner_d      = winner_q;
    frame_cnt_d   = frame_cnt_q;
    armed_d       = armed_q;
    start_d       = start_q;
    enter_serve_s = 1'b0;
`ifdef GAME_CTRL_SPEEDUP_EN
    speed_d       = speed_q;
    hit_cnt_d     = hit_cnt_q;
    hit_sum_s     = hit_cnt_q + {3'b000, bus.broken0} + {3'b000, bus.broken1};
`else
    speed_d       = 3'd1;
`endif

    frame_tick_s = (bus.hcount == 10'd0) && (bus.vcount == 10'd480);
    // Move lines sit every 8 lines from 480; the slot index must be below the current speed
    line_ofs_s   = bus.vcount - 10'd480;
    move_slot_s  = (bus.hcount == 10'd0) && (line_ofs_s <= 10'd24) &&
                   (line_ofs_s[2:0] == 3'b000) && ({1'b0, line_ofs_s[4:3]} < speed_q);
    oob_left_s   = armed_q && (bus.xloc <= XMIN);
    oob_right_s  = armed_q && (bus.xloc >= XMAX);
    sum0_s = sat_add(sat_add(score0_q, bus.broken0 ? BLOCK_PTS : 8'd0),
                     oob_right_s ? POINT_PTS : 8'd0);
    sum1_s = sat_add(sat_add(score1_q, bus.broken1 ? BLOCK_PTS : 8'd0),
                     oob_left_s ? POINT_PTS : 8'd0);

    if (bus.pixpulse) begin
      start_d = bus.start;
      move_d  = (state_q == ST_PLAY) && move_slot_s;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d       = ST_SERVE;
            enter_serve_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (frame_cnt_q == 8'd0) begin
            state_d = ST_PLAY;
            armed_d = 1'b0;
          end else begin
            state_d = ST_SERVE;
          end
        end
        ST_PLAY: begin
          // Out-of-bounds only counts once a full frame has passed in play
          if (frame_tick_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
          score0_d = sum0_s;
          score1_d = sum1_s;
          if (sum0_s >= WIN_SCORE) begin
            state_d  = ST_OVER;
            winner_d = 1'b0;
          end else if (sum1_s >= WIN_SCORE) begin
            state_d  = ST_OVER;
            winner_d = 1'b1;
          end else if (oob_left_s || oob_right_s) begin
            state_d       = ST_SERVE;
            enter_serve_s = 1'b1;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_OVER: begin
          if (bus.start && !start_q) begin
            state_d       = ST_SERVE;
            enter_serve_s = 1'b1;
            score0_d      = 8'd0;
            score1_d      = 8'd0;
          end else begin
            state_d = ST_OVER;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (enter_serve_s) begin
      frame_cnt_d = SERVE_FRAMES;
`ifdef GAME_CTRL_SPEEDUP_EN
      speed_d     = 3'd1;
      hit_cnt_d   = 4'd0;
`endif
    end else if (bus.pixpulse && (state_q == ST_SERVE) && frame_tick_s && (frame_cnt_q != 8'd0)) begin
      frame_cnt_d = frame_cnt_q - 8'd1;
`ifdef GAME_CTRL_SPEEDUP_EN
    end else if (bus.pixpulse && (state_q == ST_PLAY)) begin
      if (hit_sum_s >= HITS_PER_SPEED) begin
        hit_cnt_d = hit_sum_s - HITS_PER_SPEED;
        speed_d   = (speed_q < 3'd4) ? (speed_q + 3'd1) : 3'd4;
      end else begin
        hit_cnt_d = hit_sum_s;
      end
`endif
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    ball_reset_d = (state_d != ST_PLAY);
    game_over_d  = (state_d == ST_OVER);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      move_q       <= 1'b0;
      ball_reset_q <= 1'b1;
      score0_q     <= 8'd0;
      score1_q     <= 8'd0;
      speed_q      <= 3'd1;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      frame_cnt_q  <= 8'd0;
      armed_q      <= 1'b0;
      start_q      <= 1'b0;
`ifdef GAME_CTRL_SPEEDUP_EN
      hit_cnt_q    <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      ball_reset_q <= ball_reset_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      speed_q      <= speed_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      frame_cnt_q  <= frame_cnt_d;
      armed_q      <= armed_d;
      start_q      <= start_d;
`ifdef GAME_CTRL_SPEEDUP_EN
      hit_cnt_q    <= hit_cnt_d;
`endif
    end
  end

  assign bus.move       = move_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.score0     = score0_q;
  assign bus.score1     = score1_q;
  assign bus.speed      = speed_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: compressed raster (2 pixels x lines 479..505), rule-level match model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_game_ctrl;
  logic clk;
  logic rst;
  bit   cmp_en;
  int   total;
  int   bad;

  game_ctrl_if bus();
  game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int EXP_SPD8  = 2;
  localparam int EXP_SPD32 = 4;
`else
  localparam int EXP_SPD8  = 1;
  localparam int EXP_SPD32 = 1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raster: pixpulse 1 clk in 4; pixel advances right after each pulse
  initial begin : raster
    int ph;
    ph = 0;
    bus.pixpulse = 1'b0;
    bus.hcount   = 10'd0;
    bus.vcount   = 10'd479;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      if (ph == 1) begin
        if (bus.hcount == 10'd1) begin
          bus.hcount = 10'd0;
          bus.vcount = (bus.vcount == 10'd505) ? 10'd479 : bus.vcount + 10'd1;
        end else begin
          bus.hcount = bus.hcount + 10'd1;
        end
      end
      bus.pixpulse = (ph == 0);
    end
  end

  // Match model: phase 0 idle, 1 serve, 2 play, 3 over; plain integer bookkeeping
  int m_st, m_serve, m_sc0, m_sc1, m_spd, m_hits;
  bit m_armed, m_move, m_sl, m_win;

  always @(posedge clk or posedge rst) begin : model
    int  n0, n1, h;
    bit  tick, oob_l, oob_r, issue, to_serve;
    if (rst) begin
      m_st <= 0; m_serve <= 0; m_sc0 <= 0; m_sc1 <= 0; m_spd <= 1; m_hits <= 0;
      m_armed <= 1'b0; m_move <= 1'b0; m_sl <= 1'b0; m_win <= 1'b0;
    end else if (bus.pixpulse) begin
      tick  = (bus.hcount == 10'd0) && (bus.vcount == 10'd480);
      issue = 1'b0;
      for (int k = 0; k < m_spd; k++) begin
        if (bus.hcount == 10'd0 && int'(bus.vcount) == 480 + 8 * k) issue = 1'b1;
      end
      m_move   <= (m_st == 2) && issue;
      m_sl     <= bus.start;
      to_serve = 1'b0;
      case (m_st)
        0: if (bus.start) to_serve = 1'b1;
        1: begin
          if (m_serve == 0) begin
            m_st <= 2;
            m_armed <= 1'b0;
          end else if (tick) begin
            m_serve <= m_serve - 1;
          end
        end
        2: begin
          if (tick) m_armed <= 1'b1;
          oob_l = m_armed && (bus.xloc <= 10'd4);
          oob_r = m_armed && (bus.xloc >= 10'd636);
          n0 = m_sc0 + (bus.broken0 ? 1 : 0) + (oob_r ? 5 : 0);
          n1 = m_sc1 + (bus.broken1 ? 1 : 0) + (oob_l ? 5 : 0);
          if (n0 > 255) n0 = 255;
          if (n1 > 255) n1 = 255;
          m_sc0 <= n0;
          m_sc1 <= n1;
`ifdef GAME_CTRL_SPEEDUP_EN
          h = m_hits + (bus.broken0 ? 1 : 0) + (bus.broken1 ? 1 : 0);
          if (h >= 8) begin
            m_hits <= h - 8;
            m_spd  <= (m_spd < 4) ? m_spd + 1 : 4;
          end else begin
            m_hits <= h;
          end
`endif
          if (n0 >= 50) begin
            m_st <= 3; m_win <= 1'b0;
          end else if (n1 >= 50) begin
            m_st <= 3; m_win <= 1'b1;
          end else if (oob_l || oob_r) begin
            to_serve = 1'b1;
          end
        end
        default: begin
          if (bus.start && !m_sl) begin
            m_sc0 <= 0; m_sc1 <= 0; to_serve = 1'b1;
          end
        end
      endcase
      if (to_serve) begin
        m_st <= 1; m_serve <= 60; m_spd <= 1; m_hits <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("state", int'(bus.state), m_st);
      check("move", int'(bus.move), int'(m_move));
      check("ball_reset", int'(bus.ball_reset), (m_st != 2) ? 1 : 0);
      check("score0", int'(bus.score0), m_sc0);
      check("score1", int'(bus.score1), m_sc1);
      check("speed", int'(bus.speed), m_spd);
      check("game_over", int'(bus.game_over), (m_st == 3) ? 1 : 0);
      if (m_st == 3) check("winner", int'(bus.winner), int'(m_win));
    end
  end

  task automatic wait_pix();
    do @(posedge clk); while (!bus.pixpulse);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 20000; i++) begin
      if (bus.state == s) break;
      wait_pix();
    end
    check(name, int'(bus.state), int'(s));
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.broken0 = 1'b1;
    else bus.broken1 = 1'b1;
    wait_pix();
    bus.broken0 = 1'b0;
    bus.broken1 = 1'b0;
    wait_pix();
  endtask

  task automatic count_moves(input int exp, input string name);
    int mv;
    mv = 0;
    repeat (54) begin
      wait_pix();
      if (bus.move) mv++;
    end
    check(name, mv, exp);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int ticks, line, n;
    total = 0; bad = 0; cmp_en = 1'b0;
    rst = 1'b1;
    bus.xloc = 10'd320; bus.broken0 = 1'b0; bus.broken1 = 1'b0; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_move", int'(bus.move), 0);
    check("rst_ball_reset", int'(bus.ball_reset), 1);
    check("rst_score0", int'(bus.score0), 0);
    check("rst_score1", int'(bus.score1), 0);
    check("rst_speed", int'(bus.speed), 1);
    check("rst_game_over", int'(bus.game_over), 0);
    check("rst_winner", int'(bus.winner), 0);

    // Serve: 60 frame ticks held at start position, then play
    bus.start = 1'b1;
    wait_pix();
    bus.start = 1'b0;
    check("serve_entry", int'(bus.state), 1);
    ticks = 0;
    for (int i = 0; i < 20000 && bus.state == 2'b01; i++) begin
      wait_pix();
      if (bus.hcount == 10'd0 && bus.vcount == 10'd480) ticks++;
    end
    check("serve_ticks", ticks, 60);
    check("play_entry", int'(bus.state), 2);
    check("play_ball_reset", int'(bus.ball_reset), 0);

    // First move at line 480, high for exactly one pixel period
    for (int i = 0; i < 200 && !bus.move; i++) wait_pix();
    line = int'(bus.vcount);
    check("first_move_line", line, 480);
    n = 1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (bus.move) n++;
      else break;
    end
    check("move_clks", n, 4);

    repeat (3) pulse(0);
    check("hits_score0", int'(bus.score0), 3);
    check("hits_score1", int'(bus.score1), 0);
    check("model_score0", m_sc0, 3);

    repeat (8) pulse(1);
    check("speed_after8", int'(bus.speed), EXP_SPD8);
    count_moves(EXP_SPD8, "moves_after8");
    repeat (24) pulse(1);
    check("speed_after32", int'(bus.speed), EXP_SPD32);
    count_moves(EXP_SPD32, "moves_after32");
    check("score1_after32", int'(bus.score1), 32);

    // Left out-of-bounds: point to player 1, back to serve at speed 1
    bus.xloc = 10'd3;
    wait_pix();
    bus.xloc = 10'd320;
    check("oob_score1", int'(bus.score1), 37);
    check("oob_state", int'(bus.state), 1);
    check("oob_speed", int'(bus.speed), 1);
    check("model_score1", m_sc1, 37);

    wait_state(2'b10, "serve2_to_play");
    repeat (46) pulse(0);
    check("score0_49", int'(bus.score0), 49);
    bus.xloc = 10'd5;
    repeat (60) wait_pix();
    bus.xloc = 10'd635;
    repeat (60) wait_pix();
    bus.xloc = 10'd320;
    check("inbounds_score0", int'(bus.score0), 49);
    check("inbounds_score1", int'(bus.score1), 37);
    check("inbounds_state", int'(bus.state), 2);

    // Win on coincident hit plus right out-of-bounds, with start already held high
    bus.start = 1'b1;
    repeat (4) wait_pix();
    bus.broken0 = 1'b1;
    bus.xloc = 10'd637;
    wait_pix();
    bus.broken0 = 1'b0;
    bus.xloc = 10'd320;
    check("win_score0", int'(bus.score0), 55);
    check("win_game_over", int'(bus.game_over), 1);
    check("win_winner", int'(bus.winner), 0);
    check("win_state", int'(bus.state), 3);
    repeat (100) wait_pix();
    check("held_start_state", int'(bus.state), 3);
    bus.start = 1'b0;
    repeat (2) wait_pix();
    bus.start = 1'b1;
    wait_pix();
    bus.start = 1'b0;
    check("restart_state", int'(bus.state), 1);
    check("restart_score0", int'(bus.score0), 0);
    check("restart_score1", int'(bus.score1), 0);

    // Stale out-of-bounds xloc during the first play frame must not score
    bus.xloc = 10'd637;
    wait_state(2'b10, "serve3_to_play");
    repeat (40) wait_pix();
    check("stale_score0", int'(bus.score0), 0);
    check("stale_state", int'(bus.state), 2);
    bus.xloc = 10'd320;

    // Asynchronous reset while a move strobe is high
    for (int i = 0; i < 200 && !bus.move; i++) wait_pix();
    check("move_before_rst", int'(bus.move), 1);
    #1 rst = 1'b1;
    #1;
    check("async_move", int'(bus.move), 0);
    check("async_state", int'(bus.state), 0);
    check("async_ball_reset", int'(bus.ball_reset), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) wait_pix();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
